// File: rtl/arbitro_enrutador_if.sv
// Bus between the class/destination FIFOs and the router core.
// master = router side, slave = FIFO side.
interface arbitro_enrutador_if #(
    parameter int unsigned TAMANO_DATOS = 12
);
    logic [3:0]              fifo_empty;
    logic [TAMANO_DATOS-1:0] data_in0;
    logic [TAMANO_DATOS-1:0] data_in1;
    logic [TAMANO_DATOS-1:0] data_in2;
    logic [TAMANO_DATOS-1:0] data_in3;
    logic [3:0]              almost_full;
    logic [3:0]              pop_src;
    logic [3:0]              push_dst;
    logic [TAMANO_DATOS-1:0] data_out;

    modport master (
        input  fifo_empty, data_in0, data_in1, data_in2, data_in3, almost_full,
        output pop_src, push_dst, data_out
    );

    modport slave (
        output fifo_empty, data_in0, data_in1, data_in2, data_in3, almost_full,
        input  pop_src, push_dst, data_out
    );
endinterface

// File: rtl/arbitro_enrutador.sv
// Round-robin router from class FIFOs F0..F3 to destination FIFOs F4..F7,
// with an init state machine that latches and distributes FIFO thresholds.
module arbitro_enrutador #(
    parameter int unsigned TAMANO_DATOS = 12,
    parameter int unsigned UMBRALES_L_H = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [UMBRALES_L_H-1:0] umbral_L_in,
    input  logic [UMBRALES_L_H-1:0] umbral_H_in,
    output logic [UMBRALES_L_H-1:0] umbral_L,
    output logic [UMBRALES_L_H-1:0] umbral_H,
    output logic [1:0]              estado,
    output logic                    idle,
    arbitro_enrutador_if.master     bus
);

    localparam int unsigned DstHi = TAMANO_DATOS - 3;
    localparam int unsigned DstLo = TAMANO_DATOS - 4;

    typedef enum logic [1:0] {
        StReset  = 2'd0,
        StInit   = 2'd1,
        StIdle   = 2'd2,
        StActive = 2'd3
    } estado_e;

    estado_e                 r_state;
    estado_e                 w_state_next;
    logic [1:0]              r_ptr;
    logic [3:0]              r_push_dst;
    logic [TAMANO_DATOS-1:0] r_data_out;
    logic [UMBRALES_L_H-1:0] r_umbral_L;
    logic [UMBRALES_L_H-1:0] r_umbral_H;

    logic [TAMANO_DATOS-1:0] w_head [4];
    logic [3:0]              w_eligible;
    logic [1:0]              w_idx;
    logic [1:0]              w_grant;
    logic                    w_grant_valid;
    logic                    w_fire;
    logic [TAMANO_DATOS-1:0] w_sel_head;
    logic                    w_in_flight;

    always_comb begin
        w_head[0] = bus.data_in0;
        w_head[1] = bus.data_in1;
        w_head[2] = bus.data_in2;
        w_head[3] = bus.data_in3;
    end

    // A source is eligible only if its head's destination is not almost-full.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < 4; i++) begin
            w_eligible[i] = !bus.fifo_empty[i] && !bus.almost_full[w_head[i][DstHi:DstLo]];
        end
    end

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_idx         = '0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_eligible[w_idx]) begin
                w_grant_valid = 1'b1;
                w_grant       = w_idx;
            end
        end
    end

    assign w_fire      = (r_state == StActive) && !init && w_grant_valid;
    assign w_sel_head  = w_head[w_grant];
    assign w_in_flight = |r_push_dst;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StReset:  w_state_next = StInit;
            StInit:   if (!init) w_state_next = StIdle;
            StIdle: begin
                if (init)                    w_state_next = StInit;
                else if (!(&bus.fifo_empty)) w_state_next = StActive;
            end
            StActive: begin
                if (init)                                    w_state_next = StInit;
                else if ((&bus.fifo_empty) && !w_in_flight)  w_state_next = StIdle;
            end
            default:  w_state_next = StReset;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StReset;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= '0;
            r_push_dst <= '0;
            r_data_out <= '0;
        end else if (w_fire) begin
            r_ptr      <= w_grant + 2'd1;
            r_push_dst <= 4'b0001 << w_sel_head[DstHi:DstLo];
            r_data_out <= w_sel_head;
        end else begin
            r_push_dst <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_umbral_L <= '0;
            r_umbral_H <= '0;
        end else if ((r_state == StInit) && init) begin
            r_umbral_L <= umbral_L_in;
            r_umbral_H <= umbral_H_in;
        end
    end

    assign bus.pop_src  = w_fire ? (4'b0001 << w_grant) : 4'b0000;
    assign bus.push_dst = r_push_dst;
    assign bus.data_out = r_data_out;
    assign umbral_L     = r_umbral_L;
    assign umbral_H     = r_umbral_H;
    assign estado       = r_state;
    assign idle         = (r_state == StIdle);

endmodule

// File: doc/arbitro_enrutador.md
# arbitro_enrutador

Routing core between the four class FIFOs (F0–F3) and the four destination FIFOs (F4–F7) of the PCIE datapath. Each cycle it grants at most one non-empty class FIFO by round-robin, pops its head word and pushes it into the destination FIFO selected by the word's destination bits. A destination FIFO that reports almost-full is not sent to. It also latches and distributes the FIFO thresholds through a small init state machine.

## Interface
Parameters:
- TAMANO_DATOS, 12, word width; bits [11:10] = class, [9:8] = destination, [7:0] = payload
- UMBRALES_L_H, 8, threshold width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- init  in  1  threshold load request
- umbral_L_in  in  UMBRALES_L_H  almost-empty threshold to latch
- umbral_H_in  in  UMBRALES_L_H  almost-full threshold to latch
- fifo_empty  in  4  empty flags of F0..F3 (bit i = Fi)
- data_in0..data_in3  in  TAMANO_DATOS  head words of F0..F3 (first-word fall-through)
- almost_full  in  4  almost-full flags of F4..F7 (bit j = F(4+j))
- pop_src  out  4  one-hot pop to F0..F3
- push_dst  out  4  one-hot push to F4..F7
- data_out  out  TAMANO_DATOS  word presented with push_dst
- umbral_L, umbral_H  out  UMBRALES_L_H  registered thresholds to all FIFOs
- estado  out  2  state: 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE
- idle  out  1  high only in IDLE

## Operation
- Reset (reset=0, async): pop_src=0, push_dst=0, data_out=0, umbral_L=0, umbral_H=0, estado=RESET, idle=0, RR pointer=0. Any in-flight word is dropped.
- RESET → INIT on the first rising edge with reset=1.
- INIT: umbral_L/H load umbral_*_in on every edge while init=1. No pops. When init=0, go to IDLE.
- IDLE: idle=1. When init=1, go to INIT. Otherwise, when any fifo_empty bit is 0, go to ACTIVE.
- ACTIVE:
  - Arbitration is enabled.
  - When init=1, go to INIT. No new pops are issued; a word already in flight is still pushed.
  - When all sources are empty and no word is in flight, go to IDLE.
- Eligibility: source i is eligible when fifo_empty[i]=0 and almost_full[data_ini[9:8]]=0.
- Grant:
  - The first eligible source searching from the RR pointer upward, mod 4.
  - pop_src is combinational, one-hot, in the grant cycle, asserted only in ACTIVE.
  - The pointer moves to grant+1 (mod 4) on a grant and holds otherwise.
- Route: on the grant edge, register data_out ← the granted head and push_dst ← one-hot(head[9:8]). push_dst is 0 in cycles after a non-grant cycle.
- Words are never modified. Class bits are not checked against the source index.
- Exactly one push per pop. Never a push without a preceding pop.

## Timing
- Pop-to-push latency is 1 cycle: pop_src in cycle N gives push_dst/data_out in cycle N+1.
- Throughput is 1 word/cycle.
- almost_full is sampled in the grant cycle. One extra word may land after almost_full rises, so umbral_H must leave at least 1 free slot.
- Threshold outputs update 1 edge after init is sampled high. They hold their value outside INIT.
- Simultaneous events:
  - Blocked source: if the only non-empty source is blocked, there is no grant and the state stays ACTIVE.
  - init=1 and a grant condition in the same ACTIVE cycle: init wins and no pop is issued.
- Reset asserted mid-push clears push_dst immediately (asynchronously).

## Test plan
- Reset/init: hold reset=0 → all outputs 0, estado=0. Release with init=1, umbral_H_in=7, umbral_L_in=1 → estado=1, then umbral_H=7, umbral_L=1. Drop init → estado=2, idle=1.
- Single word: F0 head 12'h0FF, fifo_empty=4'b1110 → pop_src=0001 that cycle. Next cycle push_dst=0001, data_out=12'h0FF. After F0 empties → estado=2.
- Round-robin: all four FIFOs non-empty with heads 12'h0FF, 12'h5FF, 12'hAFF, 12'hFFF → pop_src sequence 0001, 0010, 0100, 1000, 0001. push_dst follows one cycle later as 0001, 0010, 0100, 1000.
- Backpressure: almost_full=4'b0010, F1 head 12'h5FF, others non-empty → F1 never popped. Clear almost_full → F1 popped within 4 cycles. push_dst=0010 is never asserted while almost_full[1]=1 at grant.
- Async reset mid-flight: assert reset low between pop_src=0100 and its push → push_dst=0 immediately and the word is not delivered. After release → estado=1, and the first grant goes to F0.
- init during ACTIVE: raise init in the cycle after a pop → the in-flight push still occurs, estado=1, pop_src stays 0 until init=0 and IDLE→ACTIVE.
